// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - shared state/access types and IO map constants for mem_io_arbiter
package mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACC_MEM      = 2'd0,
    ACC_LED      = 2'd1,
    ACC_SW       = 2'd2,
    ACC_UNMAPPED = 2'd3
  } access_t;

  localparam logic [21:0] IO_BASE = 22'h3FFFFF;
  localparam logic [9:0]  LED_OFS = 10'h060;
  localparam logic [9:0]  SW_OFS  = 10'h070;

endpackage

// File: rtl/mem_io_arbiter_if.sv
// rtl/mem_io_arbiter_if.sv - requester-side req/gnt/done handshake bundle
interface mem_io_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        done;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, done, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/mio_decode.sv
// rtl/mio_decode.sv - combinational address to access-type decode
module mio_decode #(
  parameter logic [21:0] IO_BASE = mio_pkg::IO_BASE,
  parameter logic [9:0]  LED_OFS = mio_pkg::LED_OFS,
  parameter logic [9:0]  SW_OFS  = mio_pkg::SW_OFS
) (
  input  logic [31:0]      i_addr,
  output mio_pkg::access_t o_acc
);
  import mio_pkg::*;

  // IO space is one 1 KiB page; only two offsets in it are backed by a device.
  always_comb begin
    o_acc = ACC_MEM;
    if (i_addr[31:10] == IO_BASE) begin
      if (i_addr[9:0] == LED_OFS)     o_acc = ACC_LED;
      else if (i_addr[9:0] == SW_OFS) o_acc = ACC_SW;
      else                            o_acc = ACC_UNMAPPED;
    end
  end
endmodule

// File: rtl/mem_io_arbiter.sv
// rtl/mem_io_arbiter.sv - round-robin arbiter for the shared memory/LED/switch access path
module mem_io_arbiter #(
  parameter int          MEM_LAT = 1,
  parameter logic [21:0] IO_BASE = mio_pkg::IO_BASE,
  parameter logic [9:0]  LED_OFS = mio_pkg::LED_OFS,
  parameter logic [9:0]  SW_OFS  = mio_pkg::SW_OFS
) (
  input  logic            clock,
  input  logic            reset,
  mem_io_arbiter_if.slave m0,
  mem_io_arbiter_if.slave m1,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic            mem_we,
  input  logic [31:0]     mem_rdata,
  input  logic [15:0]     io_rdata,
  output logic [31:0]     io_wdata,
  output logic            led_cs,
  output logic            switch_cs
);
  import mio_pkg::*;

  // Counter value of the final memory cycle; with MEM_LAT=1 the counter stays at 0.
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last;
  logic        r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  access_t     w_acc;
  logic        w_owner_sel;
  logic        w_last_cycle;
  logic        w_any_req;
  logic [31:0] w_cap_data;

  mio_decode #(
    .IO_BASE (IO_BASE),
    .LED_OFS (LED_OFS),
    .SW_OFS  (SW_OFS)
  ) u_decode (
    .i_addr (r_addr),
    .o_acc  (w_acc)
  );

  assign w_any_req   = m0.req || m1.req;
  // A lone requester wins outright; on a tie the port that did not go last wins.
  assign w_owner_sel = (m0.req && m1.req) ? ~r_last : m1.req;

  // Next state and access strobes, all derived from latched state only.
  always_comb begin
    w_next_state = r_state;
    w_last_cycle = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    io_wdata     = '0;
    led_cs       = 1'b0;
    switch_cs    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_acc == ACC_MEM) begin
          mem_addr     = r_addr;
          mem_wdata    = r_wdata;
          mem_we       = r_we && (r_cnt == 4'd0);
          w_last_cycle = (r_cnt == LAT_LAST);
        end else begin
          w_last_cycle = 1'b1;
          led_cs       = (w_acc == ACC_LED) && r_we;
          switch_cs    = (w_acc == ACC_SW) && !r_we;
          if ((w_acc == ACC_LED) && r_we) io_wdata = r_wdata;
        end
        if (w_last_cycle) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Data returned to the owner: writes, LED reads and unmapped IO read as zero.
  always_comb begin
    w_cap_data = '0;
    if (!r_we) begin
      if (w_acc == ACC_MEM)     w_cap_data = mem_rdata;
      else if (w_acc == ACC_SW) w_cap_data = {16'h0, io_rdata};
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Request latch, latency counter, read capture and round-robin history.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_owner_sel;
            r_we    <= w_owner_sel ? m1.we    : m0.we;
            r_addr  <= w_owner_sel ? m1.addr  : m0.addr;
            r_wdata <= w_owner_sel ? m1.wdata : m0.wdata;
            r_cnt   <= '0;
          end
        end
        ST_ACCESS: begin
          if (w_last_cycle) begin
            if (r_owner) r_rdata1 <= w_cap_data;
            else         r_rdata0 <= w_cap_data;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_DONE: r_last <= r_owner;
        default: ;
      endcase
    end
  end

  assign m0.gnt   = (r_state != ST_IDLE) && !r_owner;
  assign m1.gnt   = (r_state != ST_IDLE) &&  r_owner;
  assign m0.done  = (r_state == ST_DONE) && !r_owner;
  assign m1.done  = (r_state == ST_DONE) &&  r_owner;
  assign m0.rdata = r_rdata0;
  assign m1.rdata = r_rdata1;

endmodule

// File: tb/tb_mem_io_arbiter.sv
// tb/tb_mem_io_arbiter.sv - self-checking bench for mem_io_arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_mem_io_arbiter;

  localparam int K_MEM = 0;
  localparam int K_LED = 1;
  localparam int K_SW  = 2;
  localparam int K_UNM = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Data/address inputs are shared; each DUT (index 0: MEM_LAT=1, 1: MEM_LAT=3) has its own reqs.
  logic [1:0]  req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
  logic [15:0] io_rdata;

  logic [1:0][31:0]       mem_addr_o, mem_wdata_o, io_wdata_o;
  logic [1:0]             mem_we_o, led_o, sw_o;
  logic [1:0][1:0]        gnt_o, done_o;
  logic [1:0][1:0][31:0]  rdata_o;

  mem_io_arbiter_if a_m0 ();
  mem_io_arbiter_if a_m1 ();
  mem_io_arbiter_if b_m0 ();
  mem_io_arbiter_if b_m1 ();

  assign a_m0.req = req0[0]; assign a_m0.we = we0; assign a_m0.addr = addr0; assign a_m0.wdata = wdata0;
  assign a_m1.req = req1[0]; assign a_m1.we = we1; assign a_m1.addr = addr1; assign a_m1.wdata = wdata1;
  assign b_m0.req = req0[1]; assign b_m0.we = we0; assign b_m0.addr = addr0; assign b_m0.wdata = wdata0;
  assign b_m1.req = req1[1]; assign b_m1.we = we1; assign b_m1.addr = addr1; assign b_m1.wdata = wdata1;

  assign gnt_o[0]      = {a_m1.gnt, a_m0.gnt};
  assign gnt_o[1]      = {b_m1.gnt, b_m0.gnt};
  assign done_o[0]     = {a_m1.done, a_m0.done};
  assign done_o[1]     = {b_m1.done, b_m0.done};
  assign rdata_o[0][0] = a_m0.rdata;
  assign rdata_o[0][1] = a_m1.rdata;
  assign rdata_o[1][0] = b_m0.rdata;
  assign rdata_o[1][1] = b_m1.rdata;

  mem_io_arbiter #(.MEM_LAT(1)) u_dut_l1 (
    .clock(clk), .reset(rst), .m0(a_m0), .m1(a_m1),
    .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]), .mem_we(mem_we_o[0]),
    .mem_rdata(mem_rdata), .io_rdata(io_rdata), .io_wdata(io_wdata_o[0]),
    .led_cs(led_o[0]), .switch_cs(sw_o[0])
  );

  mem_io_arbiter #(.MEM_LAT(3)) u_dut_l3 (
    .clock(clk), .reset(rst), .m0(b_m0), .m1(b_m1),
    .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]), .mem_we(mem_we_o[1]),
    .mem_rdata(mem_rdata), .io_rdata(io_rdata), .io_wdata(io_wdata_o[1]),
    .led_cs(led_o[1]), .switch_cs(sw_o[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: a transaction is (owner, kind, duration); outputs follow
  // from the elapsed time t since the grant (t < dur: access, t == dur: done).
  bit          m_busy [2];
  bit          m_last [2];
  int          m_t    [2];
  int          m_dur  [2];
  int          m_kind [2];
  int          m_owner[2];
  logic        m_we   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [31:0] m_rd   [2][2];

  function automatic int kind_of(input logic [31:0] a);
    logic [31:0] page, ofs;
    page = a >> 10;
    ofs  = a & 32'h3FF;
    if (page != 32'h003F_FFFF) return K_MEM;
    if (ofs == 32'h60) return K_LED;
    if (ofs == 32'h70) return K_SW;
    return K_UNM;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0; m_last[d] = 1'b1; m_rd[d][0] = '0; m_rd[d][1] = '0;
      end else if (!m_busy[d]) begin
        if (req0[d] || req1[d]) begin
          if (req0[d] && req1[d]) m_owner[d] = m_last[d] ? 0 : 1;
          else                    m_owner[d] = req1[d] ? 1 : 0;
          m_we[d]    = (m_owner[d] == 1) ? we1    : we0;
          m_addr[d]  = (m_owner[d] == 1) ? addr1  : addr0;
          m_wdata[d] = (m_owner[d] == 1) ? wdata1 : wdata0;
          m_kind[d]  = kind_of(m_addr[d]);
          m_dur[d]   = (m_kind[d] == K_MEM) ? lat_of(d) : 1;
          m_t[d]     = 0;
          m_busy[d]  = 1'b1;
        end
      end else if (m_t[d] < m_dur[d]) begin
        if (m_t[d] == m_dur[d] - 1) begin
          if (m_we[d])                m_rd[d][m_owner[d]] = '0;
          else if (m_kind[d] == K_MEM) m_rd[d][m_owner[d]] = mem_rdata;
          else if (m_kind[d] == K_SW)  m_rd[d][m_owner[d]] = {16'h0, io_rdata};
          else                         m_rd[d][m_owner[d]] = '0;
        end
        m_t[d]++;
      end else begin
        m_last[d] = (m_owner[d] == 1);
        m_busy[d] = 1'b0;
      end
    end
  endtask

  task automatic check_dut(input int d);
    logic [1:0]  eg, ed;
    logic        ewe, eled, esw;
    logic [31:0] ea, ewd, eio;
    eg = '0; ed = '0; ewe = 1'b0; eled = 1'b0; esw = 1'b0; ea = '0; ewd = '0; eio = '0;
    if (m_busy[d]) begin
      eg[m_owner[d]] = 1'b1;
      if (m_t[d] == m_dur[d]) begin
        ed[m_owner[d]] = 1'b1;
      end else if (m_kind[d] == K_MEM) begin
        ea  = m_addr[d];
        ewd = m_wdata[d];
        ewe = m_we[d] && (m_t[d] == 0);
      end else begin
        eled = (m_kind[d] == K_LED) && m_we[d];
        esw  = (m_kind[d] == K_SW) && !m_we[d];
        eio  = eled ? m_wdata[d] : 32'h0;
      end
    end
    chk($sformatf("ctl%0d@%0d", d, cyc), {gnt_o[d], done_o[d], mem_we_o[d], led_o[d], sw_o[d]},
        {eg, ed, ewe, eled, esw});
    chk($sformatf("bus%0d@%0d", d, cyc), {mem_addr_o[d], mem_wdata_o[d], io_wdata_o[d]}, {ea, ewd, eio});
    chk($sformatf("rdata%0d@%0d", d, cyc), {rdata_o[d][1], rdata_o[d][0]}, {m_rd[d][1], m_rd[d][0]});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) check_dut(d);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [15:0] iord;
    logic [31:0] exp_rd;
    int          exp_memwe;
    int          exp_led;
    int          exp_sw;
    int          exp_lat1;
    int          exp_lat3;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    int g[2], dn[2], nwe[2], nled[2], nsw[2];
    logic [31:0] rd[2];
    for (int d = 0; d < 2; d++) begin
      g[d] = -1; dn[d] = -1; nwe[d] = 0; nled[d] = 0; nsw[d] = 0; rd[d] = '0;
    end
    mem_rdata = v.mrd;
    io_rdata  = v.iord;
    if (v.port) begin we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; req1 = 2'b11; end
    else        begin we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; req0 = 2'b11; end
    for (int k = 0; k < 20 && (dn[0] < 0 || dn[1] < 0); k++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        nwe[d]  += int'(mem_we_o[d]);
        nled[d] += int'(led_o[d]);
        nsw[d]  += int'(sw_o[d]);
        if (g[d] < 0 && gnt_o[d][v.port]) g[d] = cyc;
        if (dn[d] < 0 && done_o[d][v.port]) begin
          dn[d] = cyc;
          rd[d] = rdata_o[d][v.port];
          if (v.port) req1[d] = 1'b0; else req0[d] = 1'b0;
        end
      end
    end
    req0 = 2'b00; req1 = 2'b00;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("vec%0d_rdata_d%0d", idx, d), rd[d], v.exp_rd);
      chk($sformatf("vec%0d_lat_d%0d", idx, d), dn[d] - g[d], (d == 0) ? v.exp_lat1 : v.exp_lat3);
      chk($sformatf("vec%0d_memwe_d%0d", idx, d), nwe[d], v.exp_memwe);
      chk($sformatf("vec%0d_led_d%0d", idx, d), nled[d], v.exp_led);
      chk($sformatf("vec%0d_sw_d%0d", idx, d), nsw[d], v.exp_sw);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 5)
      0:       return {12'h0, 20'($urandom)};
      1:       return 32'hFFFF_FC60;
      2:       return 32'hFFFF_FC70;
      3:       return {22'h3FFFFF, 10'($urandom)};
      default: return 32'hFFFF_F860;
    endcase
  endfunction

  int          order0[$], order1[$];
  int          cnt_we[2], nst[2], dk[2];
  bit          ovl;
  logic [1:0]  pg;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 16'h0,    32'hDEAD_BEEF, 0, 0, 0, 1, 3};
    vecs[1] = '{1'b1, 1'b1, 32'hFFFF_FC60, 32'h0000_1234, 32'h0,         16'h0,    32'h0,         0, 1, 0, 1, 1};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FC70, 32'h0,         32'h0,         16'hA5A5, 32'h0000_A5A5, 0, 0, 1, 1, 1};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FC80, 32'h0,         32'h7777_7777, 16'h5A5A, 32'h0,         0, 0, 0, 1, 1};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h1111_1111, 16'h0,    32'h0,         1, 0, 0, 1, 3};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FC60, 32'h0,         32'h2222_2222, 16'h0F0F, 32'h0,         0, 0, 0, 1, 1};
    vecs[6] = '{1'b0, 1'b1, 32'hFFFF_FC70, 32'hBEEF_0001, 32'h0,         16'h1234, 32'h0,         0, 0, 0, 1, 1};
    vecs[7] = '{1'b1, 1'b0, 32'hFFFF_F860, 32'h0,         32'h1122_3344, 16'hFFFF, 32'h1122_3344, 0, 0, 0, 1, 3};

    rst = 1'b1; req0 = 2'b00; req1 = 2'b00; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0; io_rdata = '0;
    step();
    step();
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_state_d%0d", d),
          {gnt_o[d], done_o[d], mem_we_o[d], led_o[d], sw_o[d], mem_addr_o[d], mem_wdata_o[d], io_wdata_o[d]}, '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Both ports write continuously from reset: grants must strictly alternate from port 0.
    rst = 1'b1; step(); rst = 1'b0;
    we0 = 1'b1; we1 = 1'b1; addr0 = 32'h200; addr1 = 32'h300; wdata0 = 32'hA0A0_0000; wdata1 = 32'hB0B0_0000;
    req0 = 2'b11; req1 = 2'b11;
    cnt_we[0] = 0; cnt_we[1] = 0; ovl = 1'b0; pg = 2'b00;
    for (int k = 0; k < 40; k++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if (gnt_o[d] != 2'b00 && !pg[d]) begin
          if (d == 0) order0.push_back(gnt_o[d][1] ? 1 : 0);
          else        order1.push_back(gnt_o[d][1] ? 1 : 0);
        end
        pg[d] = (gnt_o[d] != 2'b00);
        cnt_we[d] += int'(mem_we_o[d]);
        if (done_o[d] == 2'b11) ovl = 1'b1;
      end
    end
    req0 = 2'b00; req1 = 2'b00;
    for (int k = 0; k < 6; k++) step();
    chk("contention_grants_d0", order0.size() >= 4, 1);
    chk("contention_grants_d1", order1.size() >= 4, 1);
    for (int i = 0; i < 4 && i < order0.size(); i++) chk($sformatf("order_d0_%0d", i), order0[i], i % 2);
    for (int i = 0; i < 4 && i < order1.size(); i++) chk($sformatf("order_d1_%0d", i), order1[i], i % 2);
    chk("contention_memwe_d0", cnt_we[0], order0.size());
    chk("contention_memwe_d1", cnt_we[1], order1.size());
    chk("contention_done_overlap", ovl, 0);

    // Memory read with req dropped in the second access cycle of the MEM_LAT=3 instance.
    we0 = 1'b0; addr0 = 32'h44; mem_rdata = 32'h5555_AAAA; req0 = 2'b11;
    for (int d = 0; d < 2; d++) begin nst[d] = 0; dk[d] = -1; end
    for (int k = 0; k < 12; k++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if (mem_addr_o[d] == 32'h44) nst[d]++;
        if (dk[d] < 0 && done_o[d][0]) begin dk[d] = k; req0[d] = 1'b0; end
      end
      if (k == 1) req0[1] = 1'b0;
    end
    req0 = 2'b00;
    chk("lat3_addr_cycles", nst[1], 3);
    chk("lat1_addr_cycles", nst[0], 1);
    chk("lat3_done_edge", dk[1], 3);
    chk("lat1_done_edge", dk[0], 1);

    // Reset in the second ACCESS cycle of the MEM_LAT=3 instance.
    we0 = 1'b1; addr0 = 32'h80; wdata0 = 32'h0BAD_F00D; req0 = 2'b11;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midreset_outputs",
        {gnt_o[1], done_o[1], mem_we_o[1], led_o[1], sw_o[1], mem_addr_o[1], mem_wdata_o[1], io_wdata_o[1]}, '0);
    chk("midreset_rdata", {rdata_o[1][1], rdata_o[1][0]}, '0);
    rst = 1'b0; req0 = 2'b11; req1 = 2'b11;
    step();
    chk("postreset_gnt_d1", gnt_o[1], 2'b01);
    chk("postreset_gnt_d0", gnt_o[0], 2'b01);
    req0 = 2'b00; req1 = 2'b00;
    for (int k = 0; k < 6; k++) step();

    // Randomized traffic against the reference model, including occasional resets.
    for (int k = 0; k < 2500; k++) begin
      rst = (($urandom % 100) == 0);
      for (int d = 0; d < 2; d++) begin
        req0[d] = (($urandom % 4) != 0);
        req1[d] = (($urandom % 4) != 0);
      end
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = rand_addr(); addr1 = rand_addr();
      wdata0 = $urandom; wdata1 = $urandom;
      mem_rdata = $urandom; io_rdata = 16'($urandom);
      step();
    end
    rst = 1'b0; req0 = 2'b00; req1 = 2'b00;
    for (int k = 0; k < 6; k++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
